// File: rtl/kbd_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kbd_seg_pkg
// Brief   : Shared types and constants for the keyboard-to-seven-segment
//           controller. The set-2 ASCII lookup exists only when
//           KBD_SEG_ASCII_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
package kbd_seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        BREAK   = 2'd2
    } state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Active-low patterns, bit7=a .. bit1=g, bit0=dp
    localparam logic [7:0] SEG_HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

`ifdef KBD_SEG_ASCII_EN
    // Returns {hit, ascii}; hit=0 for codes outside the letter/number rows
    function automatic logic [8:0] set2_ascii(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h41}; 8'h32: r = {1'b1, 8'h42};
            8'h21: r = {1'b1, 8'h43}; 8'h23: r = {1'b1, 8'h44};
            8'h24: r = {1'b1, 8'h45}; 8'h2B: r = {1'b1, 8'h46};
            8'h34: r = {1'b1, 8'h47}; 8'h33: r = {1'b1, 8'h48};
            8'h43: r = {1'b1, 8'h49}; 8'h3B: r = {1'b1, 8'h4A};
            8'h42: r = {1'b1, 8'h4B}; 8'h4B: r = {1'b1, 8'h4C};
            8'h3A: r = {1'b1, 8'h4D}; 8'h31: r = {1'b1, 8'h4E};
            8'h44: r = {1'b1, 8'h4F}; 8'h4D: r = {1'b1, 8'h50};
            8'h15: r = {1'b1, 8'h51}; 8'h2D: r = {1'b1, 8'h52};
            8'h1B: r = {1'b1, 8'h53}; 8'h2C: r = {1'b1, 8'h54};
            8'h3C: r = {1'b1, 8'h55}; 8'h2A: r = {1'b1, 8'h56};
            8'h1D: r = {1'b1, 8'h57}; 8'h22: r = {1'b1, 8'h58};
            8'h35: r = {1'b1, 8'h59}; 8'h1A: r = {1'b1, 8'h5A};
            8'h45: r = {1'b1, 8'h30}; 8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32}; 8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34}; 8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36}; 8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38}; 8'h46: r = {1'b1, 8'h39};
            default: r = 9'h000;
        endcase
        return r;
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/kbd_seg_ctrl_seg_hex_dec.sv
`default_nettype none
// ============================================================================
// Module  : seg_hex_dec
// Brief   : Combinational nibble to active-low seven-segment pattern.
// Revision: 1.0 - initial release
// ============================================================================
module seg_hex_dec
    import kbd_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : SEG_HEX[i_nibble];

endmodule
`default_nettype wire

// File: rtl/kbd_seg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : kbd_seg_ctrl
// Brief   : Consumes PS/2 scan codes, tracks make/break, and drives eight
//           seven-segment digits (code, ASCII, press count). The ASCII digits
//           are populated only when KBD_SEG_ASCII_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module kbd_seg_ctrl
    import kbd_seg_pkg::*;
#(
    parameter int BLANK_IDLE     = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_held, w_held_nxt;
    logic [7:0] r_count, w_count_nxt;
    logic       r_from_idle, w_from_idle_nxt;
    logic       r_shown, w_shown_nxt;
    logic       w_accept;

    assign kbd_ready = ~rst;
    assign w_accept  = kbd_valid & kbd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_held      <= 8'h00;
            r_count     <= 8'h00;
            r_from_idle <= 1'b0;
            r_shown     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_held      <= w_held_nxt;
            r_count     <= w_count_nxt;
            r_from_idle <= w_from_idle_nxt;
            r_shown     <= w_shown_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_held_nxt      = r_held;
        w_count_nxt     = r_count;
        w_from_idle_nxt = r_from_idle;
        w_shown_nxt     = r_shown;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (kbd_data == BREAK_CODE) begin
                        w_state_nxt     = BREAK;
                        w_from_idle_nxt = 1'b1;
                    end else begin
                        w_held_nxt  = kbd_data;
                        w_count_nxt = r_count + 8'd1;
                        w_shown_nxt = 1'b1;
                        w_state_nxt = PRESSED;
                    end
                end
                PRESSED: begin
                    if (kbd_data == BREAK_CODE) begin
                        w_state_nxt     = BREAK;
                        w_from_idle_nxt = 1'b0;
                    end else if (kbd_data != r_held) begin
                        w_held_nxt  = kbd_data;
                        w_count_nxt = r_count + 8'd1;
                    end
                end
                BREAK: begin
                    // Releasing some other key leaves the held key on display
                    if (r_from_idle || kbd_data == r_held) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = PRESSED;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // No key is held in IDLE nor while consuming a break that began in IDLE
    logic w_no_key;
    logic w_code_blank;
    assign w_no_key     = (w_state_nxt == IDLE) ||
                          (w_state_nxt == BREAK && w_from_idle_nxt);
    assign w_code_blank = !w_shown_nxt || ((BLANK_IDLE != 0) && w_no_key);

    logic [7:0] w_ascii;
    logic       w_ascii_hit;
`ifdef KBD_SEG_ASCII_EN
    assign {w_ascii_hit, w_ascii} = set2_ascii(w_held_nxt);
`else
    assign w_ascii_hit = 1'b0;
    assign w_ascii     = 8'h00;
`endif

    logic [7:0] w_dec_code_lo, w_dec_code_hi;
    logic [7:0] w_dec_asc_lo, w_dec_asc_hi;
    logic [7:0] w_dec_cnt_lo, w_dec_cnt_hi;
    logic       w_asc_blank;
    assign w_asc_blank = w_code_blank || !w_ascii_hit;

    seg_hex_dec u_dec_code_lo (.i_nibble(w_held_nxt[3:0]),  .i_blank(w_code_blank), .o_seg(w_dec_code_lo));
    seg_hex_dec u_dec_code_hi (.i_nibble(w_held_nxt[7:4]),  .i_blank(w_code_blank), .o_seg(w_dec_code_hi));
    seg_hex_dec u_dec_asc_lo  (.i_nibble(w_ascii[3:0]),     .i_blank(w_asc_blank),  .o_seg(w_dec_asc_lo));
    seg_hex_dec u_dec_asc_hi  (.i_nibble(w_ascii[7:4]),     .i_blank(w_asc_blank),  .o_seg(w_dec_asc_hi));
    seg_hex_dec u_dec_cnt_lo  (.i_nibble(w_count_nxt[3:0]), .i_blank(1'b0),         .o_seg(w_dec_cnt_lo));
    seg_hex_dec u_dec_cnt_hi  (.i_nibble(w_count_nxt[7:4]), .i_blank(1'b0),         .o_seg(w_dec_cnt_hi));

    function automatic logic [7:0] pol(input logic [7:0] p);
        return (SEG_ACTIVE_LOW != 0) ? p : ~p;
    endfunction

    // Digits load from next-state values so they track an accepted byte on the same edge as the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            o_seg0 <= pol(SEG_BLANK);
            o_seg1 <= pol(SEG_BLANK);
            o_seg2 <= pol(SEG_BLANK);
            o_seg3 <= pol(SEG_BLANK);
            o_seg4 <= pol(SEG_BLANK);
            o_seg5 <= pol(SEG_BLANK);
            o_seg6 <= pol(SEG_HEX[0]);
            o_seg7 <= pol(SEG_HEX[0]);
        end else begin
            o_seg0 <= pol(w_dec_code_lo);
            o_seg1 <= pol(w_dec_code_hi);
            o_seg2 <= pol(w_dec_asc_lo);
            o_seg3 <= pol(w_dec_asc_hi);
            o_seg4 <= pol(SEG_BLANK);
            o_seg5 <= pol(SEG_BLANK);
            o_seg6 <= pol(w_dec_cnt_lo);
            o_seg7 <= pol(w_dec_cnt_hi);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kbd_seg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_kbd_seg_ctrl
// Brief   : Self-checking bench for kbd_seg_ctrl (vector table + scoreboard).
//           Expected ASCII digits follow KBD_SEG_ASCII_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_kbd_seg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_valid = 1'b0;
    logic       kbd_ready;
    logic [7:0] seg [8];

    always #5 clk = ~clk;

    kbd_seg_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .o_seg0    (seg[0]),
        .o_seg1    (seg[1]),
        .o_seg2    (seg[2]),
        .o_seg3    (seg[3]),
        .o_seg4    (seg[4]),
        .o_seg5    (seg[5]),
        .o_seg6    (seg[6]),
        .o_seg7    (seg[7])
    );

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       show;
        logic [7:0] code;
        logic       ahit;
        logic [7:0] ascii;
        logic [7:0] cnt;
    } vec_t;

    vec_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 8'h03; 4'h1: return 8'h9F; 4'h2: return 8'h25; 4'h3: return 8'h0D;
            4'h4: return 8'h99; 4'h5: return 8'h49; 4'h6: return 8'h41; 4'h7: return 8'h1F;
            4'h8: return 8'h01; 4'h9: return 8'h09; 4'hA: return 8'h11; 4'hB: return 8'hC1;
            4'hC: return 8'h63; 4'hD: return 8'h85; 4'hE: return 8'h61; default: return 8'h71;
        endcase
    endfunction

    function automatic logic [63:0] exp_segs(input vec_t e);
        logic [7:0] s [8];
        logic       asc_on;
`ifdef KBD_SEG_ASCII_EN
        asc_on = e.show && e.ahit;
`else
        asc_on = 1'b0;
`endif
        s[0] = e.show ? hexseg(e.code[3:0]) : 8'hFF;
        s[1] = e.show ? hexseg(e.code[7:4]) : 8'hFF;
        s[2] = asc_on ? hexseg(e.ascii[3:0]) : 8'hFF;
        s[3] = asc_on ? hexseg(e.ascii[7:4]) : 8'hFF;
        s[4] = 8'hFF;
        s[5] = 8'hFF;
        s[6] = hexseg(e.cnt[3:0]);
        s[7] = hexseg(e.cnt[7:4]);
        return {s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]};
    endfunction

    task automatic step(input vec_t v, input string name);
        vec_t       e;
        logic [63:0] act, want;
        rst       = v.r;
        kbd_valid = v.v;
        kbd_data  = v.d;
        q_exp.push_back(v);
        @(posedge clk);
        #1;
        e    = q_exp.pop_front();
        want = exp_segs(e);
        act  = {seg[7], seg[6], seg[5], seg[4], seg[3], seg[2], seg[1], seg[0]};
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s segs: got %h want %h", name, act, want);
        end
        n_checks++;
        if (kbd_ready !== ~e.r) begin
            n_fail++;
            $display("FAIL %s kbd_ready: got %b want %b", name, kbd_ready, ~e.r);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic show, input logic [7:0] code,
                                input logic ahit, input logic [7:0] ascii,
                                input logic [7:0] cnt);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.show = show; t.code = code;
        t.ahit = ahit; t.ascii = ascii; t.cnt = cnt;
        return t;
    endfunction

    vec_t tbl [29];

    initial begin
        //           r  v  data   show code  ahit ascii  cnt
        tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00); // reset
        tbl[1]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
        tbl[2]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
        tbl[3]  = mk(0, 1, 8'h1C, 1, 8'h1C, 1, 8'h41, 8'h01); // make A
        tbl[4]  = mk(0, 1, 8'h1C, 1, 8'h1C, 1, 8'h41, 8'h01); // repeat
        tbl[5]  = mk(0, 1, 8'h1C, 1, 8'h1C, 1, 8'h41, 8'h01);
        tbl[6]  = mk(0, 1, 8'hF0, 1, 8'h1C, 1, 8'h41, 8'h01);
        tbl[7]  = mk(0, 1, 8'h1C, 0, 8'h1C, 1, 8'h41, 8'h01); // released
        tbl[8]  = mk(0, 0, 8'h1C, 0, 8'h1C, 1, 8'h41, 8'h01);
        tbl[9]  = mk(0, 1, 8'h1C, 1, 8'h1C, 1, 8'h41, 8'h02);
        tbl[10] = mk(0, 1, 8'h32, 1, 8'h32, 1, 8'h42, 8'h03); // new key, no break
        tbl[11] = mk(0, 1, 8'hF0, 1, 8'h32, 1, 8'h42, 8'h03);
        tbl[12] = mk(0, 1, 8'h1C, 1, 8'h32, 1, 8'h42, 8'h03); // break of other key
        tbl[13] = mk(0, 1, 8'hF0, 1, 8'h32, 1, 8'h42, 8'h03);
        tbl[14] = mk(0, 1, 8'h32, 0, 8'h32, 1, 8'h42, 8'h03);
        tbl[15] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
        tbl[16] = mk(0, 1, 8'h15, 1, 8'h15, 1, 8'h51, 8'h01); // back-to-back
        tbl[17] = mk(0, 1, 8'hF0, 1, 8'h15, 1, 8'h51, 8'h01);
        tbl[18] = mk(0, 1, 8'h15, 0, 8'h15, 1, 8'h51, 8'h01);
        tbl[19] = mk(0, 1, 8'h24, 1, 8'h24, 1, 8'h45, 8'h02);
        tbl[20] = mk(0, 1, 8'hF0, 1, 8'h24, 1, 8'h45, 8'h02);
        tbl[21] = mk(1, 1, 8'h24, 0, 8'h00, 0, 8'h00, 8'h00); // reset mid-break
        tbl[22] = mk(0, 1, 8'h15, 1, 8'h15, 1, 8'h51, 8'h01); // fresh make
        tbl[23] = mk(0, 1, 8'hF0, 1, 8'h15, 1, 8'h51, 8'h01);
        tbl[24] = mk(0, 1, 8'h15, 0, 8'h15, 1, 8'h51, 8'h01);
        tbl[25] = mk(0, 1, 8'hF0, 0, 8'h15, 1, 8'h51, 8'h01); // F0 from idle
        tbl[26] = mk(0, 1, 8'h1C, 0, 8'h15, 1, 8'h51, 8'h01); // consumed as break
        tbl[27] = mk(0, 0, 8'h1C, 0, 8'h15, 1, 8'h51, 8'h01);
        tbl[28] = mk(0, 1, 8'h76, 1, 8'h76, 0, 8'h00, 8'h02); // unmapped code

        @(posedge clk);
        #1;
        for (int i = 0; i < 29; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Counter wrap: 256 make/break pairs then one more make
        step(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00), "wrap_rst");
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = 8'(i + 1);
            step(mk(0, 1, 8'h16, 1, 8'h16, 1, 8'h31, c), "wrap_make");
            step(mk(0, 1, 8'hF0, 1, 8'h16, 1, 8'h31, c), "wrap_f0");
            step(mk(0, 1, 8'h16, 0, 8'h16, 1, 8'h31, c), "wrap_brk");
        end
        step(mk(0, 0, 8'h00, 0, 8'h16, 1, 8'h31, 8'h00), "wrap_zero");
        step(mk(0, 1, 8'h16, 1, 8'h16, 1, 8'h31, 8'h01), "wrap_257");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
